// File: rtl/sobel_frame_sequencer_if.sv
// Handshake bundle between the Sobel frame sequencer and the blocks it drives
// (frame-start source, memory read/write unit, 3x3 window buffer).
//
// Signals:
//   start       frame start request (source -> sequencer)
//   mem_busy    read/write unit busy, no issue while high
//   read_done   one-cycle pulse, read data presented to the window buffer
//   shift_done  one-cycle pulse, window shift complete
//   write_done  one-cycle pulse, write committed
//   start_read  one-cycle read request, addr_r valid alongside
//   start_shift one-cycle window shift command
//   start_write one-cycle write request, addr_w valid alongside
//   busy        high from start acceptance until frame completion
//   done        one-cycle pulse when the frame is complete
//
// master: the sequencer side.  slave: the datapath / environment side.
interface sobel_frame_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic              mem_busy;
    logic              read_done;
    logic              shift_done;
    logic              write_done;
    logic              start_read;
    logic [ADDR_W-1:0] addr_r;
    logic              start_shift;
    logic              start_write;
    logic [ADDR_W-1:0] addr_w;
    logic              busy;
    logic              done;

    modport master (
        input  start, mem_busy, read_done, shift_done, write_done,
        output start_read, addr_r, start_shift, start_write, addr_w, busy, done
    );

    modport slave (
        output start, mem_busy, read_done, shift_done, write_done,
        input  start_read, addr_r, start_shift, start_write, addr_w, busy, done
    );
endinterface

// File: rtl/sobel_frame_sequencer.sv
// Sobel frame sequencer: raster-scans the interior rows of the input frame.
// For every column it reads the three vertically stacked pixels that form the
// window buffer's new column, commands a window shift, and once the window is
// primed (third column onward) writes the filtered result for the centre
// pixel. It moves no pixel data itself; it only sequences the datapath.
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset; aborts any frame in progress
//   bus   sobel_frame_sequencer_if.master (start / mem_busy / *_done in,
//         start_read+addr_r / start_shift / start_write+addr_w / busy / done out)
//
// All outputs are registered. A done input is only honoured in its matching
// WAIT state and not in the cycle its request pulse is visible, so at most
// one operation is ever outstanding.
module sobel_frame_sequencer #(
    parameter int                IMG_W    = 16,
    parameter int                IMG_H    = 16,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] BASE_IN  = '0,
    parameter logic [ADDR_W-1:0] BASE_OUT = ADDR_W'(16'h8000)
) (
    input  logic                   clk,
    input  logic                   rst,
    sobel_frame_sequencer_if.master bus
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int Y_W   = $clog2(IMG_H);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(IMG_H - 2);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ROW_STEP2 = ADDR_W'(2 * IMG_W);
    // row_base points at row y-1 of the input; the output centre pixel is at
    // row y, column col-1 of the output frame.
    localparam logic [ADDR_W-1:0] WR_OFS    = ROW_STEP + BASE_OUT - BASE_IN - ADDR_W'(1);

    typedef enum logic [3:0] {
        IDLE,
        ROW_INIT,
        RD_ISSUE,
        RD_WAIT,
        SH_ISSUE,
        SH_WAIT,
        WR_ISSUE,
        WR_WAIT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [1:0]        r_q, r_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;

    logic              start_read_q, start_read_d;
    logic [ADDR_W-1:0] addr_r_q, addr_r_d;
    logic              start_shift_q, start_shift_d;
    logic              start_write_q, start_write_d;
    logic [ADDR_W-1:0] addr_w_q, addr_w_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] r_ofs;
    logic [ADDR_W-1:0] col_ext;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;

    // r*IMG_W from a constant mux, r only ever takes 0..2
    always_comb begin
        case (r_q)
            2'd1:    r_ofs = ROW_STEP;
            2'd2:    r_ofs = ROW_STEP2;
            default: r_ofs = '0;
        endcase
    end

    assign col_ext = ADDR_W'(col_q);
    assign rd_addr = row_base_q + r_ofs + col_ext;
    assign wr_addr = row_base_q + WR_OFS + col_ext;

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        y_d           = y_q;
        r_d           = r_q;
        row_base_d    = row_base_q;
        start_read_d  = 1'b0;
        addr_r_d      = addr_r_q;
        start_shift_d = 1'b0;
        start_write_d = 1'b0;
        addr_w_d      = addr_w_q;
        busy_d        = busy_q;
        done_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = ROW_INIT;
                    y_d        = Y_W'(1);
                    col_d      = '0;
                    row_base_d = BASE_IN;
                    busy_d     = 1'b1;
                end
            end
            ROW_INIT: begin
                r_d     = '0;
                state_d = RD_ISSUE;
            end
            RD_ISSUE: begin
                if (!bus.mem_busy) begin
                    start_read_d = 1'b1;
                    addr_r_d     = rd_addr;
                    state_d      = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // start_read_q high means the request is only now visible
                if (bus.read_done && !start_read_q) begin
                    if (r_q < 2'd2) begin
                        r_d     = r_q + 2'd1;
                        state_d = RD_ISSUE;
                    end else begin
                        state_d = SH_ISSUE;
                    end
                end
            end
            SH_ISSUE: begin
                start_shift_d = 1'b1;
                state_d       = SH_WAIT;
            end
            SH_WAIT: begin
                if (bus.shift_done && !start_shift_q) begin
                    // first two columns only prime the window, nothing to write
                    if (col_q < COL_W'(2)) begin
                        col_d   = col_q + COL_W'(1);
                        r_d     = '0;
                        state_d = RD_ISSUE;
                    end else begin
                        state_d = WR_ISSUE;
                    end
                end
            end
            WR_ISSUE: begin
                if (!bus.mem_busy) begin
                    start_write_d = 1'b1;
                    addr_w_d      = wr_addr;
                    state_d       = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (bus.write_done && !start_write_q) begin
                    if (col_q < COL_LAST) begin
                        col_d   = col_q + COL_W'(1);
                        r_d     = '0;
                        state_d = RD_ISSUE;
                    end else if (y_q < Y_LAST) begin
                        y_d        = y_q + Y_W'(1);
                        row_base_d = row_base_q + ROW_STEP;
                        col_d      = '0;
                        state_d    = ROW_INIT;
                    end else begin
                        // done and the busy drop land in the same cycle
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            col_q         <= '0;
            y_q           <= '0;
            r_q           <= '0;
            row_base_q    <= '0;
            start_read_q  <= 1'b0;
            addr_r_q      <= '0;
            start_shift_q <= 1'b0;
            start_write_q <= 1'b0;
            addr_w_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            y_q           <= y_d;
            r_q           <= r_d;
            row_base_q    <= row_base_d;
            start_read_q  <= start_read_d;
            addr_r_q      <= addr_r_d;
            start_shift_q <= start_shift_d;
            start_write_q <= start_write_d;
            addr_w_q      <= addr_w_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus.start_read  = start_read_q;
    assign bus.addr_r      = addr_r_q;
    assign bus.start_shift = start_shift_q;
    assign bus.start_write = start_write_q;
    assign bus.addr_w      = addr_w_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Bench for sobel_frame_sequencer: a 4x4 instance and a 3x3 instance share
// one set of stimulus signals, routed by 'sel'. The reference model lists the
// expected request stream (reads / shifts / writes with addresses) straight
// from the frame geometry.
module tb_sobel_frame_sequencer;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst;
    logic sel;
    logic start, mem_busy, read_done, shift_done, write_done;

    always #5 clk = ~clk;

    sobel_frame_sequencer_if #(.ADDR_W(AW)) ifa ();
    sobel_frame_sequencer_if #(.ADDR_W(AW)) ifb ();

    assign ifa.start      = start      & ~sel;
    assign ifa.mem_busy   = mem_busy   & ~sel;
    assign ifa.read_done  = read_done  & ~sel;
    assign ifa.shift_done = shift_done & ~sel;
    assign ifa.write_done = write_done & ~sel;
    assign ifb.start      = start      & sel;
    assign ifb.mem_busy   = mem_busy   & sel;
    assign ifb.read_done  = read_done  & sel;
    assign ifb.shift_done = shift_done & sel;
    assign ifb.write_done = write_done & sel;

    logic          o_sr, o_ss, o_sw, o_busy, o_done;
    logic [AW-1:0] o_ar, o_aw;
    assign o_sr   = sel ? ifb.start_read  : ifa.start_read;
    assign o_ss   = sel ? ifb.start_shift : ifa.start_shift;
    assign o_sw   = sel ? ifb.start_write : ifa.start_write;
    assign o_busy = sel ? ifb.busy        : ifa.busy;
    assign o_done = sel ? ifb.done        : ifa.done;
    assign o_ar   = sel ? ifb.addr_r      : ifa.addr_r;
    assign o_aw   = sel ? ifb.addr_w      : ifa.addr_w;

    sobel_frame_sequencer #(
        .IMG_W(4), .IMG_H(4), .ADDR_W(AW), .BASE_IN(16'h0000), .BASE_OUT(16'h8000)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.master)
    );

    sobel_frame_sequencer #(
        .IMG_W(3), .IMG_H(3), .ADDR_W(AW), .BASE_IN(16'h0000), .BASE_OUT(16'h8000)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.master)
    );

    int total = 0;
    int bad   = 0;

    // observed / expected request streams: kind 1=read 2=shift 3=write
    int            obs_k[$];
    logic [AW-1:0] obs_a[$];
    int            exp_k[$];
    logic [AW-1:0] exp_a[$];

    int n_done, cyc, fall_cyc, rd_after_fall, mb_err, busy_err, excl_err;

    task automatic build_model(input int w, input int h);
        exp_k.delete();
        exp_a.delete();
        for (int y = 1; y <= h - 2; y++) begin
            for (int c = 0; c < w; c++) begin
                for (int r = 0; r < 3; r++) begin
                    exp_k.push_back(1);
                    exp_a.push_back(AW'((y - 1 + r) * w + c));
                end
                exp_k.push_back(2);
                exp_a.push_back('0);
                if (c >= 2) begin
                    exp_k.push_back(3);
                    exp_a.push_back(AW'(32'h8000 + y * w + c - 1));
                end
            end
        end
    endtask

    function automatic int count_kind(input int k);
        int n = 0;
        foreach (obs_k[i]) if (obs_k[i] == k) n++;
        return n;
    endfunction

    // mode 0: done 1 cycle after each request, mem_busy low
    // mode 1: random response delays, random mem_busy, random stray done pulses
    // mode 2: mem_busy held 5 cycles as the 5th read is about to be issued
    // mode 3: every done delivery raises all three done lines, start pulsed mid-frame
    task automatic run_frame(input int mode, input bit abort_wr);
        int   pend, kind, dly, mb_hold, nrd, t;
        bit   fin, abrt;
        logic mb_prev;
        pend = 0; kind = 0; mb_hold = 0; nrd = 0; fin = 0; abrt = 0;
        obs_k.delete();
        obs_a.delete();
        n_done = 0; cyc = 0; fall_cyc = -1; rd_after_fall = -1;
        mb_err = 0; busy_err = 0; excl_err = 0;
        @(negedge clk);
        start = 1'b1;
        while (!fin && !abrt && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            mb_prev    = mem_busy;
            start      = 1'b0;
            read_done  = 1'b0;
            shift_done = 1'b0;
            write_done = 1'b0;
            if (mode == 1) begin
                mem_busy = ($urandom_range(0, 3) == 0);
            end else if (mb_hold > 0) begin
                mem_busy = 1'b1;
                mb_hold--;
            end else begin
                if (mem_busy && fall_cyc < 0) fall_cyc = cyc;
                mem_busy = 1'b0;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    case (kind)
                        1:       read_done  = 1'b1;
                        2:       shift_done = 1'b1;
                        default: write_done = 1'b1;
                    endcase
                    if (mode == 3) begin
                        read_done = 1'b1; shift_done = 1'b1; write_done = 1'b1;
                    end
                    if (mode == 2 && kind == 1) begin
                        nrd++;
                        if (nrd == 4) mb_hold = 5;
                    end
                    kind = 0;
                end
            end
            if (mode == 3 && cyc % 5 == 2) start = 1'b1;
            if (mode == 1 && $urandom_range(0, 4) == 0) begin
                t = $urandom_range(1, 3);
                if (t != kind) begin
                    case (t)
                        1:       read_done  = 1'b1;
                        2:       shift_done = 1'b1;
                        default: write_done = 1'b1;
                    endcase
                end
            end
            dly = (mode == 1) ? $urandom_range(1, 3) : 1;
            if (int'(o_sr) + int'(o_ss) + int'(o_sw) > 1) excl_err++;
            if (!o_done && o_busy !== 1'b1) busy_err++;
            if (o_sr === 1'b1) begin
                obs_k.push_back(1); obs_a.push_back(o_ar);
                if (mb_prev) mb_err++;
                kind = 1; pend = dly;
                if (fall_cyc >= 0 && rd_after_fall < 0) rd_after_fall = cyc;
            end
            if (o_ss === 1'b1) begin
                obs_k.push_back(2); obs_a.push_back('0);
                kind = 2; pend = dly;
            end
            if (o_sw === 1'b1) begin
                obs_k.push_back(3); obs_a.push_back(o_aw);
                if (mb_prev) mb_err++;
                kind = 3; pend = dly;
                if (abort_wr) abrt = 1;
            end
            if (o_done === 1'b1) begin
                n_done++;
                fin = 1;
                total++;
                if (o_busy !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_at_done: busy=%b required 0", o_busy);
                end
            end
        end
        if (!fin && !abrt) begin
            total++; bad++;
            $display("FAIL frame_timeout: no done after %0d cycles", cyc);
        end
        start = 1'b0; read_done = 1'b0; shift_done = 1'b0; write_done = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic test_reset();
        sel = 1'b0;
        rst = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            total++;
            if ({o_sr, o_ss, o_sw, o_busy, o_done, o_ar, o_aw} !== '0) begin
                bad++;
                $display("FAIL reset_outputs dut%0d: got %b %b %b %b %b %h %h required all 0",
                         s, o_sr, o_ss, o_sw, o_busy, o_done, o_ar, o_aw);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_frame_4x4();
        logic [AW-1:0] wexp[4];
        logic [AW-1:0] wobs[$];
        int extra;
        wexp = '{16'h8005, 16'h8006, 16'h8009, 16'h800A};
        sel = 1'b0;
        build_model(4, 4);
        run_frame(0, 1'b0);
        total++;
        if (count_kind(1) != 24) begin bad++; $display("FAIL f1_reads: got %0d required 24", count_kind(1)); end
        total++;
        if (count_kind(2) != 8) begin bad++; $display("FAIL f1_shifts: got %0d required 8", count_kind(2)); end
        total++;
        if (count_kind(3) != 4) begin bad++; $display("FAIL f1_writes: got %0d required 4", count_kind(3)); end
        foreach (obs_k[i]) if (obs_k[i] == 3) wobs.push_back(obs_a[i]);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= wobs.size() || wobs[i] !== wexp[i]) begin
                bad++;
                $display("FAIL f1_addr_w[%0d]: got %h required %h", i,
                         (i < wobs.size()) ? wobs[i] : 16'hxxxx, wexp[i]);
            end
        end
        total++;
        if (busy_err != 0 || excl_err != 0) begin
            bad++; $display("FAIL f1_busy_excl: busy_err=%0d excl_err=%0d required 0", busy_err, excl_err);
        end
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_done !== 1'b0 || o_busy !== 1'b0) extra++;
        end
        total++;
        if (n_done + extra != 1) begin
            bad++; $display("FAIL f1_done_once: done/busy events=%0d required 1", n_done + extra);
        end
    endtask

    task automatic test_first_row();
        int            ek[16];
        logic [AW-1:0] ea[16];
        ek = '{1, 1, 1, 2, 1, 1, 1, 2, 1, 1, 1, 2, 3, 1, 1, 1};
        ea = '{16'd0, 16'd4, 16'd8, 16'd0, 16'd1, 16'd5, 16'd9, 16'd0,
               16'd2, 16'd6, 16'd10, 16'd0, 16'h8005, 16'd3, 16'd7, 16'd11};
        sel = 1'b0;
        run_frame(0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            total++;
            if (i >= obs_k.size() || obs_k[i] != ek[i] || obs_a[i] !== ea[i]) begin
                bad++;
                $display("FAIL row_order[%0d]: got kind=%0d addr=%h required kind=%0d addr=%h", i,
                         (i < obs_k.size()) ? obs_k[i] : -1, (i < obs_a.size()) ? obs_a[i] : 16'hxxxx,
                         ek[i], ea[i]);
            end
        end
    endtask

    task automatic test_mem_busy();
        sel = 1'b0;
        build_model(4, 4);
        run_frame(2, 1'b0);
        total++;
        if (mb_err != 0) begin bad++; $display("FAIL busy_issue: issues while mem_busy=%0d required 0", mb_err); end
        total++;
        if (fall_cyc < 0 || rd_after_fall - fall_cyc != 1) begin
            bad++; $display("FAIL busy_release: read at cycle %0d, mem_busy fell at %0d, required 1 later",
                            rd_after_fall, fall_cyc);
        end
        total++;
        if (obs_k.size() != exp_k.size()) begin
            bad++; $display("FAIL mb_len: got %0d required %0d", obs_k.size(), exp_k.size());
        end
        foreach (exp_k[i]) if (i < obs_k.size()) begin
            total++;
            if (obs_k[i] != exp_k[i] || obs_a[i] !== exp_a[i]) begin
                bad++; $display("FAIL mb_stream[%0d]: got %0d/%h required %0d/%h", i, obs_k[i], obs_a[i], exp_k[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_random();
        sel = 1'b0;
        build_model(4, 4);
        for (int f = 0; f < 3; f++) begin
            run_frame(1, 1'b0);
            total++;
            if (mb_err != 0 || busy_err != 0 || excl_err != 0 || n_done != 1) begin
                bad++; $display("FAIL rnd_rules f%0d: mb_err=%0d busy_err=%0d excl_err=%0d done=%0d required 0/0/0/1",
                                f, mb_err, busy_err, excl_err, n_done);
            end
            total++;
            if (obs_k.size() != exp_k.size()) begin
                bad++; $display("FAIL rnd_len f%0d: got %0d required %0d", f, obs_k.size(), exp_k.size());
            end
            foreach (exp_k[i]) if (i < obs_k.size()) begin
                total++;
                if (obs_k[i] != exp_k[i] || obs_a[i] !== exp_a[i]) begin
                    bad++; $display("FAIL rnd_stream f%0d[%0d]: got %0d/%h required %0d/%h", f, i, obs_k[i], obs_a[i], exp_k[i], exp_a[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int act;
        sel = 1'b0;
        run_frame(0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({o_sr, o_ss, o_sw, o_busy, o_done, o_ar, o_aw} !== '0) begin
            bad++; $display("FAIL midreset_outputs: got %b %b %b %b %b %h %h required all 0",
                            o_sr, o_ss, o_sw, o_busy, o_done, o_ar, o_aw);
        end
        rst = 1'b0;
        write_done = 1'b1;
        @(negedge clk);
        write_done = 1'b0;
        act = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_sr || o_ss || o_sw || o_busy || o_done) act++;
        end
        total++;
        if (act != 0) begin bad++; $display("FAIL midreset_quiet: active cycles=%0d required 0", act); end
        build_model(4, 4);
        run_frame(0, 1'b0);
        total++;
        if (obs_k.size() == 0 || obs_k[0] != 1 || obs_a[0] !== 16'h0000) begin
            bad++; $display("FAIL restart_first_read: got %h required 0000", (obs_a.size() > 0) ? obs_a[0] : 16'hxxxx);
        end
        total++;
        if (obs_k.size() != exp_k.size() || n_done != 1) begin
            bad++; $display("FAIL restart_len: got %0d events %0d done required %0d and 1", obs_k.size(), n_done, exp_k.size());
        end
        foreach (exp_k[i]) if (i < obs_k.size()) begin
            total++;
            if (obs_k[i] != exp_k[i] || obs_a[i] !== exp_a[i]) begin
                bad++; $display("FAIL restart_stream[%0d]: got %0d/%h required %0d/%h", i, obs_k[i], obs_a[i], exp_k[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_spurious();
        sel = 1'b0;
        build_model(4, 4);
        run_frame(3, 1'b0);
        total++;
        if (count_kind(1) != 24 || count_kind(2) != 8 || count_kind(3) != 4 || n_done != 1) begin
            bad++; $display("FAIL spur_counts: got r=%0d s=%0d w=%0d done=%0d required 24/8/4/1",
                            count_kind(1), count_kind(2), count_kind(3), n_done);
        end
        total++;
        if (obs_k.size() != exp_k.size()) begin
            bad++; $display("FAIL spur_len: got %0d required %0d", obs_k.size(), exp_k.size());
        end
        foreach (exp_k[i]) if (i < obs_k.size()) begin
            total++;
            if (obs_k[i] != exp_k[i] || obs_a[i] !== exp_a[i]) begin
                bad++; $display("FAIL spur_stream[%0d]: got %0d/%h required %0d/%h", i, obs_k[i], obs_a[i], exp_k[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_small_3x3();
        logic [AW-1:0] wa;
        sel = 1'b1;
        build_model(3, 3);
        run_frame(0, 1'b0);
        total++;
        if (count_kind(1) != 9 || count_kind(2) != 3 || count_kind(3) != 1 || n_done != 1) begin
            bad++; $display("FAIL small_counts: got r=%0d s=%0d w=%0d done=%0d required 9/3/1/1",
                            count_kind(1), count_kind(2), count_kind(3), n_done);
        end
        wa = 'x;
        foreach (obs_k[i]) if (obs_k[i] == 3) wa = obs_a[i];
        total++;
        if (wa !== 16'h8004) begin bad++; $display("FAIL small_addr_w: got %h required 8004", wa); end
        foreach (exp_k[i]) if (i < obs_k.size()) begin
            total++;
            if (obs_k[i] != exp_k[i] || obs_a[i] !== exp_a[i]) begin
                bad++; $display("FAIL small_stream[%0d]: got %0d/%h required %0d/%h", i, obs_k[i], obs_a[i], exp_k[i], exp_a[i]);
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; start = 1'b0; mem_busy = 1'b0;
        read_done = 1'b0; shift_done = 1'b0; write_done = 1'b0;
        test_reset();
        test_frame_4x4();
        test_first_row();
        test_mem_busy();
        test_reset_mid();
        test_spurious();
        test_random();
        test_small_3x3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sobel_frame_sequencer.md
Name: sobel_frame_sequencer

Overview:
- Top-level controller for the Sobel edge pipeline. It raster-scans the input frame and drives the memory read/write unit and the 3x3 window buffer.
- Per output pixel it issues the pixel reads that fill the window buffer's new column, commands a window shift, then issues the write of the filtered result.
- It only sequences the other blocks. It computes no pixel data and sits between the frame-start source and the datapath.

Parameters:
- IMG_W, 16, frame width in pixels (>=3)
- IMG_H, 16, frame height in pixels (>=3)
- ADDR_W, 16, memory address width
- BASE_IN, 0, word address of input pixel (0,0)
- BASE_OUT, 16'h8000, word address of output pixel (0,0)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  frame start request; accepted only in IDLE
- mem_busy  in  1  read/write unit busy; no issue while high
- read_done  in  1  one-cycle pulse, read data presented to window buffer
- shift_done  in  1  one-cycle pulse, window shift complete
- write_done  in  1  one-cycle pulse, write committed
- start_read  out  1  one-cycle read request pulse
- addr_r  out  ADDR_W  read address, valid while start_read high
- start_shift  out  1  one-cycle shift command pulse
- start_write  out  1  one-cycle write request pulse
- addr_w  out  ADDR_W  write address, valid while start_write high
- busy  out  1  high from start acceptance until DONE
- done  out  1  one-cycle pulse when frame complete

Behaviour:
- One clock and one reset. Reset is synchronous and active-high (rst sampled on rising clk).
- Reset values: all outputs 0, state IDLE, all counters 0. Reset mid-frame aborts immediately. Done pulses still in flight are ignored after reset.
- Registered state: col (0..IMG_W-1), y (1..IMG_H-2), r (0..2), row_base = BASE_IN + (y-1)*IMG_W. row_base is updated by adding IMG_W; no multiplier.
- States and transitions:
  - IDLE: on start -> ROW_INIT. Sets y=1, col=0, row_base=BASE_IN, busy=1.
  - ROW_INIT: r=0 -> RD_ISSUE.
  - RD_ISSUE: waits while mem_busy=1. Otherwise pulses start_read with addr_r = row_base + r*IMG_W + col -> RD_WAIT.
  - RD_WAIT: on read_done, if r<2 then r++ -> RD_ISSUE; else -> SH_ISSUE.
  - SH_ISSUE: pulses start_shift -> SH_WAIT.
  - SH_WAIT: on shift_done, if col<2 then col++, r=0 -> RD_ISSUE (row prefill); else -> WR_ISSUE.
  - WR_ISSUE: waits while mem_busy=1. Otherwise pulses start_write with addr_w = BASE_OUT + y*IMG_W + (col-1) -> WR_WAIT. The y*IMG_W term comes from registered row_base + IMG_W - BASE_IN + BASE_OUT arithmetic.
  - WR_WAIT: on write_done:
    - if col<IMG_W-1: col++, r=0 -> RD_ISSUE;
    - else if y<IMG_H-2: y++, row_base+=IMG_W, col=0 -> ROW_INIT;
    - else -> DONE.
  - DONE: pulses done, clears busy -> IDLE.
- Done inputs are honoured only in their matching WAIT state. They are accepted no earlier than the cycle after the issue pulse. Pulses arriving in any other state are ignored.
- Exactly one outstanding memory or shift operation at any time. start_read, start_shift and start_write are mutually exclusive.
- start while busy is ignored. start in the same cycle as rst is ignored.
- Per frame (W=IMG_W, H=IMG_H):
  - reads = 3*W*(H-2)
  - shifts = W*(H-2)
  - writes = (W-2)*(H-2)
- Border output pixels are never written.
- Address arithmetic is modulo 2^ADDR_W (wraps silently).

Test Plan:
1. IMG_W=4, IMG_H=4, done inputs returned 1 cycle after each request, mem_busy=0 -> 24 reads, 8 shifts, 4 writes. addr_w sequence 0x8005, 0x8006, 0x8009, 0x800A. done pulses once; busy falls the same cycle.
2. Same config, check first row reads -> addr_r order 0,4,8,1,5,9,2,6,10, then shift, then write 0x8005, then reads 3,7,11.
3. Hold mem_busy=1 for 5 cycles when RD_ISSUE is entered -> no start_read during those cycles; exactly one start_read the cycle after mem_busy falls, with an unchanged address.
4. Assert rst while in WR_WAIT, then deliver write_done -> all outputs 0, state IDLE, no done pulse. A new start begins again at addr_r=BASE_IN.
5. Pulse start while busy=1, and inject a spurious shift_done during RD_WAIT -> sequence and counts identical to scenario 1.
6. IMG_W=3, IMG_H=3 -> 9 reads, 3 shifts, a single write at addr_w=0x8004, then done.
